// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : 32x32 integer register file with write-to-read bypass and a
//               pending-load scoreboard that drives the ID-stage busy flags.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWrite_MEMWB,
    input  logic [4:0]      rd_MEMWB,
    input  logic [XLEN-1:0] wbData_WB,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    output logic [XLEN-1:0] rs1Data_ID,
    output logic [XLEN-1:0] rs2Data_ID,
    input  logic            issueValid_ID,
    input  logic            issueMemRead_ID,
    input  logic [4:0]      issueRd_ID,
    input  logic            flush_EX,
    output logic            rs1Busy_ID,
    output logic            rs2Busy_ID
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;
    logic             ex_valid;
    logic [4:0]       ex_rd;
    logic             mem_valid;
    logic [4:0]       mem_rd;

    logic wr_en;
    logic issue_load;
    logic hit1;
    logic hit2;
    logic flush_kill;

    assign wr_en      = regWrite_MEMWB && (rd_MEMWB != 5'd0);
    assign issue_load = issueValid_ID && issueMemRead_ID && (issueRd_ID != 5'd0);
    assign hit1       = regWrite_MEMWB && (rd_MEMWB == rs1_ID);
    assign hit2       = regWrite_MEMWB && (rd_MEMWB == rs2_ID);

    // A squashed load must not release a bit still owned by an older load in MEM.
    assign flush_kill = flush_EX && ex_valid && !(mem_valid && (mem_rd == ex_rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd_MEMWB] <= wbData_WB;
        end
    end

    // Read outputs are forced to zero for the whole reset window, bypass included.
    always_comb begin
        rs1Data_ID = '0;
        rs2Data_ID = '0;
        if (!rst && (rs1_ID != 5'd0)) begin
            rs1Data_ID = hit1 ? wbData_WB : regs[rs1_ID];
        end
        if (!rst && (rs2_ID != 5'd0)) begin
            rs2Data_ID = hit2 ? wbData_WB : regs[rs2_ID];
        end
    end

    // Clears are applied first so a same-edge set of the same index wins.
    always_comb begin
        pend_next = pend;
        if (regWrite_MEMWB) begin
            pend_next[rd_MEMWB] = 1'b0;
        end
        if (flush_kill) begin
            pend_next[ex_rd] = 1'b0;
        end
        if (issue_load) begin
            pend_next[issueRd_ID] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            ex_valid  <= 1'b0;
            ex_rd     <= 5'd0;
            mem_valid <= 1'b0;
            mem_rd    <= 5'd0;
        end else begin
            pend      <= pend_next;
            ex_valid  <= issue_load;
            ex_rd     <= issueRd_ID;
            mem_valid <= ex_valid && !flush_EX;
            mem_rd    <= ex_rd;
        end
    end

    assign rs1Busy_ID = pend[rs1_ID] && !hit1;
    assign rs2Busy_ID = pend[rs2_ID] && !hit2;

endmodule
`default_nettype wire
